// File: rtl/store_write_buffer.sv
// Posted store buffer: steers store data onto byte lanes, queues entries in a
// small FIFO and drains them to the data memory over a valid/ready handshake.
module store_write_buffer #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          st_valid,
  input  logic [1:0]    st_mode,
  input  logic [31:0]   st_addr,
  input  logic [31:0]   st_data,
  output logic          st_ready,
  output logic          st_misalign,
  input  logic          ld_check,
  input  logic [31:0]   ld_addr,
  output logic          ld_hazard,
  output logic          mem_valid,
  input  logic          mem_ready,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_be,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [29:0]    r_addr  [DEPTH];
  logic [31:0]    r_wdata [DEPTH];
  logic [3:0]     r_be    [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [CW-1:0]  r_count;
  logic           r_misalign;
  logic [29:0]    r_mem_addr;
  logic [31:0]    r_mem_wdata;
  logic [3:0]     r_mem_be;

  logic           w_full;
  logic           w_empty;
  logic           w_accept;
  logic           w_misalign;
  logic           w_push;
  logic           w_pop;
  logic [1:0]     w_off;
  logic [31:0]    w_wdata;
  logic [3:0]     w_be;
  logic [AW-1:0]  w_rptr_nxt;
  logic [CW-1:0]  w_count_nxt;
  logic [29:0]    w_head_addr;
  logic [31:0]    w_head_wdata;
  logic [3:0]     w_head_be;
  logic           w_hit;
  logic           w_unused_ld;

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_accept = st_valid && !w_full;
  assign w_push   = w_accept && !w_misalign;
  assign w_pop    = !w_empty && mem_ready;
  assign w_off    = st_addr[1:0];

  assign st_ready    = !w_full;
  assign empty       = w_empty;
  assign mem_valid   = !w_empty;
  assign count       = r_count;
  assign st_misalign = r_misalign;
  assign mem_addr    = {r_mem_addr, 2'b00};
  assign mem_wdata   = r_mem_wdata;
  assign mem_be      = r_mem_be;
  assign w_unused_ld = &{1'b0, ld_addr[1:0]};

  // Lane steering and alignment check; mode 11 behaves as a word store.
  always_comb begin
    w_wdata    = st_data;
    w_be       = 4'b1111;
    w_misalign = 1'b0;
    case (st_mode)
      2'b00: begin
        w_wdata = {4{st_data[7:0]}};
        w_be    = 4'b0001 << w_off;
      end
      2'b01: begin
        w_wdata    = {2{st_data[15:0]}};
        w_be       = w_off[1] ? 4'b1100 : 4'b0011;
        w_misalign = w_off[0];
      end
      default: begin
        w_wdata    = st_data;
        w_be       = 4'b1111;
        w_misalign = (w_off != 2'b00);
      end
    endcase
  end

  always_comb begin
    w_rptr_nxt  = w_pop ? r_rptr + AW'(1) : r_rptr;
    w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
  end

  // Next head payload; the slot being written this cycle may become the head.
  always_comb begin
    w_head_addr  = r_addr[w_rptr_nxt];
    w_head_wdata = r_wdata[w_rptr_nxt];
    w_head_be    = r_be[w_rptr_nxt];
    if (w_push && (r_wptr == w_rptr_nxt)) begin
      w_head_addr  = st_addr[31:2];
      w_head_wdata = w_wdata;
      w_head_be    = w_be;
    end
  end

  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && (r_addr[i] == ld_addr[31:2])) begin
        w_hit = 1'b1;
      end
    end
  end

  assign ld_hazard = ld_check && w_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i]  <= '0;
        r_wdata[i] <= '0;
        r_be[i]    <= '0;
      end
      r_vld      <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_misalign <= 1'b0;
    end else begin
      if (w_pop) begin
        r_vld[r_rptr] <= 1'b0;
      end
      if (w_push) begin
        r_addr[r_wptr]  <= st_addr[31:2];
        r_wdata[r_wptr] <= w_wdata;
        r_be[r_wptr]    <= w_be;
        r_vld[r_wptr]   <= 1'b1;
        r_wptr          <= r_wptr + AW'(1);
      end
      r_rptr     <= w_rptr_nxt;
      r_count    <= w_count_nxt;
      r_misalign <= w_accept && w_misalign;
    end
  end

  // Memory-port payload registers; they hold their value while the buffer is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
    end else if (w_count_nxt != '0) begin
      r_mem_addr  <= w_head_addr;
      r_mem_wdata <= w_head_wdata;
      r_mem_be    <= w_head_be;
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// Scoreboard bench for store_write_buffer: directed scenarios plus random
// traffic checked against a queue-based reference model.
module tb_store_write_buffer;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          st_valid;
  logic [1:0]    st_mode;
  logic [31:0]   st_addr;
  logic [31:0]   st_data;
  logic          st_ready;
  logic          st_misalign;
  logic          ld_check;
  logic [31:0]   ld_addr;
  logic          ld_hazard;
  logic          mem_valid;
  logic          mem_ready;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic          empty;
  logic [CW-1:0] count;

  store_write_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_mode(st_mode), .st_addr(st_addr), .st_data(st_data),
    .st_ready(st_ready), .st_misalign(st_misalign),
    .ld_check(ld_check), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } wr_t;

  int errors = 0;
  int checks = 0;

  wr_t         exp_q[$];
  logic [29:0] mdl_words[$];
  int          mdl_cnt = 0;
  logic        mdl_mis = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic wr_t expect_write(input logic [1:0] mode, input logic [31:0] addr,
                                       input logic [31:0] data);
    wr_t w;
    int off;
    off     = int'(addr % 4);
    w.addr  = addr - (addr % 4);
    if (mode == 2'd0) begin
      w.wdata = data[7:0] * 32'h0101_0101;
      w.be    = 4'(1 << off);
    end else if (mode == 2'd1) begin
      w.wdata = data[15:0] * 32'h0001_0001;
      w.be    = (off >= 2) ? 4'hC : 4'h3;
    end else begin
      w.wdata = data;
      w.be    = 4'hF;
    end
    return w;
  endfunction

  function automatic bit is_misaligned(input logic [1:0] mode, input logic [31:0] addr);
    if (mode == 2'd0) return 1'b0;
    if (mode == 2'd1) return (addr % 2) != 0;
    return (addr % 4) != 0;
  endfunction

  task automatic drive(input logic v, input logic [1:0] mode, input logic [31:0] addr,
                       input logic [31:0] data, input logic rdy, input logic ldc,
                       input logic [31:0] lda);
    @(posedge clk);
    #1;
    st_valid  = v;
    st_mode   = mode;
    st_addr   = addr;
    st_data   = data;
    mem_ready = rdy;
    ld_check  = ldc;
    ld_addr   = lda;
  endtask

  // Check status outputs against the model, then advance the model across the next edge.
  task automatic settle();
    bit hz;
    bit acc, mis, push, pop;
    @(negedge clk);
    hz = 1'b0;
    foreach (mdl_words[i]) if (mdl_words[i] == ld_addr[31:2]) hz = 1'b1;
    chk("st_ready",    32'(st_ready),    32'(mdl_cnt < DEPTH));
    chk("empty",       32'(empty),       32'(mdl_cnt == 0));
    chk("mem_valid",   32'(mem_valid),   32'(mdl_cnt > 0));
    chk("count",       32'(count),       32'(mdl_cnt));
    chk("st_misalign", 32'(st_misalign), 32'(mdl_mis));
    chk("ld_hazard",   32'(ld_hazard),   32'(ld_check && hz));
    #1;
    pop  = (mdl_cnt > 0) && mem_ready;
    acc  = st_valid && (mdl_cnt < DEPTH);
    mis  = acc && is_misaligned(st_mode, st_addr);
    push = acc && !mis;
    if (pop) void'(mdl_words.pop_front());
    if (push) begin
      mdl_words.push_back(st_addr[31:2]);
      exp_q.push_back(expect_write(st_mode, st_addr, st_data));
    end
    mdl_cnt = mdl_cnt + int'(push) - int'(pop);
    mdl_mis = mis;
  endtask

  task automatic step(input logic v, input logic [1:0] mode, input logic [31:0] addr,
                      input logic [31:0] data, input logic rdy, input logic ldc,
                      input logic [31:0] lda);
    drive(v, mode, addr, data, rdy, ldc, lda);
    settle();
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 2'd0, 32'h0, 32'h0, rdy, 1'b0, 32'h0);
  endtask

  // Monitor: whenever the head is presented it must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mem_unexpected: got addr %h with no pending write expected at %0t",
                 mem_addr, $time);
      end else begin
        chk("mem_addr",  mem_addr,        exp_q[0].addr);
        chk("mem_wdata", mem_wdata,       exp_q[0].wdata);
        chk("mem_be",    32'(mem_be),     32'(exp_q[0].be));
        if (mem_ready === 1'b1) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [1:0]  m;
    logic [31:0] a, d;
    rst_n = 1'b0; st_valid = 1'b0; st_mode = 2'd0; st_addr = '0; st_data = '0;
    mem_ready = 1'b0; ld_check = 1'b0; ld_addr = '0;
    #2;
    chk("rst_count",     32'(count),       0);
    chk("rst_empty",     32'(empty),       1);
    chk("rst_st_ready",  32'(st_ready),    1);
    chk("rst_mem_valid", 32'(mem_valid),   0);
    chk("rst_mem_addr",  mem_addr,         0);
    chk("rst_mem_wdata", mem_wdata,        0);
    chk("rst_mem_be",    32'(mem_be),      0);
    chk("rst_misalign",  32'(st_misalign), 0);
    #1 rst_n = 1'b1;

    // Lane steering
    step(1'b1, 2'd0, 32'h103, 32'h0000_00AB, 1'b1, 1'b0, 32'h0);
    idle(1'b1);
    chk("sb_addr", mem_addr, 32'h100);
    chk("sb_wdata", mem_wdata, 32'hABAB_ABAB);
    chk("sb_be", 32'(mem_be), 32'h8);
    step(1'b1, 2'd1, 32'h202, 32'h0000_BEEF, 1'b1, 1'b0, 32'h0);
    idle(1'b1);
    chk("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
    chk("sh_be", 32'(mem_be), 32'hC);
    step(1'b1, 2'd2, 32'h300, 32'h1234_5678, 1'b1, 1'b0, 32'h0);
    idle(1'b1);
    chk("sw_be", 32'(mem_be), 32'hF);
    idle(1'b1);
    chk("hold_after_empty", mem_wdata, 32'h1234_5678);

    // Misaligned stores are dropped with a one-cycle pulse
    step(1'b1, 2'd2, 32'h101, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
    idle(1'b1);
    chk("sw_mis_pulse", 32'(st_misalign), 1);
    chk("sw_mis_count", 32'(count), 0);
    idle(1'b1);
    chk("sw_mis_one_cycle", 32'(st_misalign), 0);
    step(1'b1, 2'd1, 32'h001, 32'h0000_1234, 1'b1, 1'b0, 32'h0);
    idle(1'b1);
    chk("sh_mis_pulse", 32'(st_misalign), 1);
    chk("sh_mis_count", 32'(count), 0);

    // Backpressure: five stores offered against a stalled memory
    for (int i = 0; i < 5; i++)
      step(1'b1, 2'd2, 32'h500 + 32'(4 * i), 32'h5500 + 32'(i), 1'b0, 1'b0, 32'h0);
    chk("full_count", 32'(count), 4);
    chk("full_st_ready", 32'(st_ready), 0);
    step(1'b1, 2'd2, 32'h510, 32'h5504, 1'b0, 1'b0, 32'h0);
    chk("full_held", 32'(count), 4);
    for (int i = 0; i < 4; i++) idle(1'b1);
    idle(1'b0);
    chk("full_drained", 32'(count), 0);

    // Simultaneous push and pop at count 2
    step(1'b1, 2'd2, 32'h600, 32'h6600, 1'b0, 1'b0, 32'h0);
    step(1'b1, 2'd2, 32'h604, 32'h6601, 1'b0, 1'b0, 32'h0);
    step(1'b1, 2'd2, 32'h608, 32'h6602, 1'b1, 1'b0, 32'h0);
    idle(1'b0);
    chk("pushpop_count", 32'(count), 2);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Load hazard against a pending byte store
    step(1'b1, 2'd0, 32'h40, 32'h11, 1'b0, 1'b0, 32'h0);
    step(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h43);
    chk("hz_hit", 32'(ld_hazard), 1);
    step(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h44);
    chk("hz_other_word", 32'(ld_hazard), 0);
    step(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h43);
    chk("hz_popping_head", 32'(ld_hazard), 1);
    step(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h43);
    chk("hz_after_drain", 32'(ld_hazard), 0);

    // Asynchronous reset with three pending entries
    for (int i = 0; i < 3; i++)
      step(1'b1, 2'd2, 32'h700 + 32'(4 * i), 32'h7700 + 32'(i), 1'b0, 1'b0, 32'h0);
    drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_mem_valid", 32'(mem_valid), 0);
    chk("arst_st_ready", 32'(st_ready), 1);
    chk("arst_mem_be", 32'(mem_be), 0);
    mdl_cnt = 0;
    mdl_words.delete();
    exp_q.delete();
    mdl_mis = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      m = 2'($urandom_range(0, 3));
      a = 32'h1000 + 32'($urandom_range(0, 31));
      d = $urandom;
      if (m == 2'd0) d = d & 32'hFF;
      else if (m == 2'd1) d = d & 32'hFFFF;
      step(1'($urandom_range(0, 9) < 6), m, a, d, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 32'h1000 + 32'($urandom_range(0, 35)));
    end

    for (int n = 0; n < 20 && mdl_cnt > 0; n++) idle(1'b1);
    idle(1'b1);
    chk("final_count", 32'(count), 0);
    chk("final_scoreboard_left", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish by %0t", $time);
    $fatal(1);
  end
endmodule
